mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 88 ++++++++
 tb/tb_mem_arbiter.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter between an instruction-fetch port and a data port onto one memory port
module mem_arbiter #(
    parameter int TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_i,
    input  logic [31:0] addr_i,
    output logic        done_i,
    output logic [31:0] rdata_i,
    input  logic        req_d,
    input  logic        we_d,
    input  logic [3:0]  be_d,
    input  logic [31:0] addr_d,
    input  logic [31:0] wdata_d,
    output logic        done_d,
    output logic [31:0] rdata_d,
    output logic        err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t state, state_next;
    logic sel_d, cur_d, last_d, timeout_hit;
    logic [7:0] cnt;
    // Pick data only when fetch is absent or fetch was the last one served
    always_comb begin
        sel_d = req_d && (!req_i || !last_d);
        timeout_hit = ({1'b0, cnt} + 9'd1) == 9'(TIMEOUT);
    end
    // Next-state logic; an empty byte mask skips the memory access entirely
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (req_i || req_d) state_next = (sel_d && be_d == 4'b0000) ? DONE : BUSY;
            BUSY: if (mem_ack || timeout_hit) state_next = DONE;
            default: state_next = IDLE;
        endcase
    end
    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else state <= state_next;
    end
    // Grant latching, wait counter and read-data capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_d <= 1'b0;
            last_d <= 1'b1;
            cnt <= 8'd0;
            err <= 1'b0;
            rdata_i <= 32'd0;
            rdata_d <= 32'd0;
            mem_we <= 1'b0;
            mem_be <= 4'd0;
            mem_addr <= 32'd0;
            mem_wdata <= 32'd0;
        end else if (state == IDLE && (req_i || req_d)) begin
            cur_d <= sel_d;
            last_d <= sel_d;
            cnt <= 8'd0;
            err <= sel_d && be_d == 4'b0000;
            mem_we <= sel_d ? we_d : 1'b0;
            mem_be <= sel_d ? be_d : 4'b1111;
            mem_addr <= sel_d ? addr_d : (addr_i & 32'hFFFF_FFFC);
            mem_wdata <= sel_d ? wdata_d : 32'd0;
        end else if (state == BUSY) begin
            if (mem_ack || timeout_hit) begin
                err <= !mem_ack;
                if (cur_d) rdata_d <= mem_ack ? mem_rdata : 32'd0;
                else rdata_i <= mem_ack ? mem_rdata : 32'd0;
            end else begin
                cnt <= cnt + 8'd1;
            end
        end
    end
    // Strobe and completion pulses follow the state directly
    always_comb begin
        mem_req = state == BUSY;
        done_i = state == DONE && !cur_d;
        done_d = state == DONE && cur_d;
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scoreboard bench for mem_arbiter
module tb_mem_arbiter;
    logic clk = 0, rst = 1;
    logic req_i = 0, req_d = 0, we_d = 0, mem_ack = 0;
    logic [3:0] be_d = 0;
    logic [31:0] addr_i = 0, addr_d = 0, wdata_d = 0, mem_rdata = 0;
    logic done_i, done_d, err, mem_req, mem_we;
    logic [31:0] rdata_i, rdata_d, mem_addr, mem_wdata;
    logic [3:0] mem_be;
    int compared = 0, mismatched = 0;

    typedef struct {
        logic is_d;
        logic chk_data;
        logic [31:0] data;
        logic err;
    } exp_t;
    exp_t sb[$];

    mem_arbiter #(.TIMEOUT(15)) dut (
        .clk(clk), .rst(rst), .req_i(req_i), .addr_i(addr_i), .done_i(done_i), .rdata_i(rdata_i),
        .req_d(req_d), .we_d(we_d), .be_d(be_d), .addr_d(addr_d), .wdata_d(wdata_d),
        .done_d(done_d), .rdata_d(rdata_d), .err(err), .mem_req(mem_req), .mem_we(mem_we),
        .mem_be(mem_be), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_ack(mem_ack)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic is_d, input logic chk_data, input logic [31:0] data, input logic e);
        exp_t x;
        x.is_d = is_d;
        x.chk_data = chk_data;
        x.data = data;
        x.err = e;
        sb.push_back(x);
    endtask

    // Scoreboard: every completion pulse must match the oldest expected result
    always @(negedge clk) begin
        if (done_i || done_d) begin
            check("done_onehot", {31'd0, done_i & done_d}, 32'd0);
            if (sb.size() == 0) begin
                check("unexpected_done", {31'd0, done_i | done_d}, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("done_kind", {31'd0, done_d}, {31'd0, e.is_d});
                check("done_err", {31'd0, err}, {31'd0, e.err});
                if (e.chk_data) check("done_rdata", done_d ? rdata_d : rdata_i, e.data);
            end
        end
    end

    initial begin
        step;
        step;
        check("rst_mem_req", {31'd0, mem_req}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_be", {28'd0, mem_be}, 32'd0);
        check("rst_rdata_i", rdata_i, 32'd0);
        check("rst_rdata_d", rdata_d, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        rst = 0;
        step;
        // zero-wait fetch with unaligned address
        req_i = 1; addr_i = 32'h23; mem_ack = 1; mem_rdata = 32'h8f000000;
        push(0, 1, 32'h8f000000, 0);
        step;
        check("f_mem_req", {31'd0, mem_req}, 32'd1);
        check("f_mem_addr", mem_addr, 32'h20);
        check("f_mem_be", {28'd0, mem_be}, 32'hf);
        check("f_mem_we", {31'd0, mem_we}, 32'd0);
        step;
        check("f_done_i", {31'd0, done_i}, 32'd1);
        check("f_mem_req_off", {31'd0, mem_req}, 32'd0);
        req_i = 0; mem_ack = 0;
        step;
        // store with three wait cycles
        req_d = 1; we_d = 1; be_d = 4'b0011; addr_d = 32'h10; wdata_d = 32'hAF000000;
        mem_rdata = 32'h12345678;
        push(1, 1, 32'h12345678, 0);
        for (int i = 0; i < 4; i++) begin
            step;
            check("s_mem_req", {31'd0, mem_req}, 32'd1);
            check("s_fields", {mem_we, 27'd0, mem_be}, {1'b1, 27'd0, 4'b0011});
            check("s_addr", mem_addr, 32'h10);
            check("s_wdata", mem_wdata, 32'hAF000000);
            check("s_no_done", {30'd0, done_i, done_d}, 32'd0);
            if (i == 3) mem_ack = 1;
        end
        step;
        check("s_done_d", {31'd0, done_d}, 32'd1);
        req_d = 0; mem_ack = 0; we_d = 0;
        step;
        check("hold_rdata_i", rdata_i, 32'h8f000000);
        check("hold_rdata_d", rdata_d, 32'h12345678);
        // round-robin after reset: fetch, data, fetch
        rst = 1;
        step;
        rst = 0;
        req_i = 1; req_d = 1; addr_i = 32'h100; addr_d = 32'h40; be_d = 4'b1111; mem_ack = 1;
        for (int k = 0; k < 3; k++) begin
            mem_rdata = 32'hA0 + k;
            push(k == 1, 1, 32'hA0 + k, 0);
            step;
            check("rr_grant_addr", mem_addr, (k == 1) ? 32'h40 : 32'h100);
            step;
            check("rr_done", {30'd0, done_i, done_d}, (k == 1) ? 32'd1 : 32'd2);
            if (k == 2) begin
                req_i = 0; req_d = 0;
            end
            step;
        end
        // timeout on fetch
        req_i = 1; addr_i = 32'h200; mem_ack = 0; mem_rdata = 32'hDEAD;
        push(0, 1, 32'd0, 1);
        for (int i = 0; i < 15; i++) begin
            step;
            check("to_mem_req", {31'd0, mem_req}, 32'd1);
        end
        step;
        check("to_done_i", {31'd0, done_i}, 32'd1);
        check("to_mem_req_off", {31'd0, mem_req}, 32'd0);
        req_i = 0;
        step;
        // empty byte mask completes with error and no memory access
        req_d = 1; be_d = 4'b0000; we_d = 1; mem_ack = 1;
        push(1, 0, 32'd0, 1);
        step;
        check("be0_mem_req", {31'd0, mem_req}, 32'd0);
        check("be0_done_d", {31'd0, done_d}, 32'd1);
        req_d = 0; mem_ack = 0; we_d = 0; be_d = 4'b1111;
        step;
        // reset while busy
        req_i = 1; addr_i = 32'h300;
        step;
        check("rb_mem_req", {31'd0, mem_req}, 32'd1);
        #2 rst = 1;
        #1 check("rb_mem_req_async", {31'd0, mem_req}, 32'd0);
        req_i = 0;
        step;
        step;
        rst = 0;
        step;
        req_i = 1; addr_i = 32'h304; mem_ack = 1; mem_rdata = 32'h55;
        push(0, 1, 32'h55, 0);
        step;
        check("rb_after_addr", mem_addr, 32'h304);
        step;
        check("rb_after_done", {31'd0, done_i}, 32'd1);
        req_i = 0; mem_ack = 0;
        step;
        step;
        check("sb_empty", sb.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
